// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sipo_frame_ctrl
// Brief   : Serial-in/parallel-out frame receiver (start, WIDTH data MSB
//           first, stop) with a one-word valid/ready output holding register.
// Revision: 1.0 - initial release
// ============================================================================
module sipo_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             SI,
    input  logic             SV,
    input  logic             RDY,
    input  logic             CLR,
    output logic [WIDTH-1:0] PO,
    output logic             VLD,
    output logic             BUSY,
    output logic             OVR,
    output logic             FERR
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   po_q, po_d;
    logic               vld_q, vld_d;
    logic               ovr_q, ovr_d;
    logic               ferr_q, ferr_d;
    logic               w_good_stop;
    logic               w_ovr_set;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ferr_d      = 1'b0;
        w_good_stop = 1'b0;

        case (state_q)
            IDLE: begin
                if (SV && SI) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (SV) begin
                    sr_d  = {sr_q[WIDTH-2:0], SI};
                    cnt_d = cnt_q + c_CNT_W'(1);
                    if (cnt_q == c_CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (SV) begin
                    state_d = IDLE;
                    // A high stop bit discards the word and only pulses FERR.
                    if (!SI) begin
                        w_good_stop = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        po_d      = po_q;
        vld_d     = vld_q;
        w_ovr_set = 1'b0;

        if (w_good_stop) begin
            if (!vld_q || RDY) begin
                po_d  = sr_q;
                vld_d = 1'b1;
            end else begin
                w_ovr_set = 1'b1;
            end
        end else if (vld_q && RDY) begin
            vld_d = 1'b0;
        end

        // Setting takes priority over a simultaneous clear.
        ovr_d = w_ovr_set | (ovr_q & ~CLR);
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            po_q    <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            po_q    <= po_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign PO   = po_q;
    assign VLD  = vld_q;
    assign OVR  = ovr_q;
    assign FERR = ferr_q;
    assign BUSY = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sipo_frame_ctrl
// Brief   : Scoreboard bench: frame-level model pushes expected words, a
//           consumer-side monitor pops them on every VLD/RDY handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sipo_frame_ctrl;

    logic       C   = 1'b0;
    logic       R   = 1'b0;
    logic       SI  = 1'b0;
    logic       SV  = 1'b0;
    logic       RDY = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] PO;
    logic       VLD;
    logic       BUSY;
    logic       OVR;
    logic       FERR;

    sipo_frame_ctrl #(.WIDTH(8)) dut (
        .C    (C),
        .R    (R),
        .SI   (SI),
        .SV   (SV),
        .RDY  (RDY),
        .CLR  (CLR),
        .PO   (PO),
        .VLD  (VLD),
        .BUSY (BUSY),
        .OVR  (OVR),
        .FERR (FERR)
    );

    always #5 C = ~C;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       m_vld    = 1'b0;
    logic       exp_ovr  = 1'b0;
    logic       exp_busy = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       mon_en   = 1'b0;
    logic       clr_next = 1'b0;
    int         rdy_mode = 1;   // 0 random, 1 low, 2 high, 3 high only on good stop
    int         clr_rate = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Flag checks just after each edge against the model's post-edge values.
    always @(posedge C) begin
        #1;
        if (mon_en) begin
            chk("vld",  {31'd0, VLD},  {31'd0, m_vld});
            chk("ovr",  {31'd0, OVR},  {31'd0, exp_ovr});
            chk("busy", {31'd0, BUSY}, {31'd0, exp_busy});
            chk("ferr", {31'd0, FERR}, {31'd0, exp_ferr});
        end
    end

    // Consumer side: the word shown must be the queue head; a handshake retires it.
    always @(negedge C) begin
        if (mon_en && !R && VLD === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL po_scoreboard: actual=%0h required=none (queue empty)", PO);
            end else begin
                chk("po", {24'd0, PO}, {24'd0, exp_q[0]});
                if (RDY) void'(exp_q.pop_front());
            end
        end
    end

    // kind: 0 none/gap, 1 start, 2 data, 3 good stop, 4 bad stop, 5 reset
    task automatic step(input logic sv, input logic si, input int kind, input logic [7:0] w);
        logic set;
        SV = sv;
        SI = si;
        R  = (kind == 5);
        case (rdy_mode)
            0:       RDY = 1'($urandom_range(0, 1));
            1:       RDY = 1'b0;
            2:       RDY = 1'b1;
            default: RDY = (kind == 3);
        endcase
        if (kind == 5) RDY = 1'b0;
        CLR = clr_next | (clr_rate != 0 && $urandom_range(1, clr_rate) == 1);
        clr_next = 1'b0;
        if (kind == 5) begin
            m_vld    = 1'b0;
            exp_ovr  = 1'b0;
            exp_busy = 1'b0;
            exp_ferr = 1'b0;
            exp_q.delete();
        end else begin
            set      = 1'b0;
            exp_ferr = (kind == 4);
            if (kind == 1) exp_busy = 1'b1;
            else if (kind >= 3) exp_busy = 1'b0;
            if (kind == 3) begin
                if (!m_vld || RDY) begin
                    exp_q.push_back(w);
                    m_vld = 1'b1;
                end else begin
                    set = 1'b1;
                end
            end else if (m_vld && RDY) begin
                m_vld = 1'b0;
            end
            exp_ovr = set | (exp_ovr & ~CLR);
        end
        @(posedge C);
        #2;
    endtask

    task automatic gap(input int gmin, input int gmax);
        repeat ($urandom_range(gmin, gmax)) step(1'b0, 1'($urandom_range(0, 1)), 0, 8'd0);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic bad_stop, input int gmin, input int gmax);
        step(1'b1, 1'b1, 1, 8'd0);
        for (int i = 7; i >= 0; i--) begin
            gap(gmin, gmax);
            step(1'b1, w[i], 2, 8'd0);
        end
        gap(gmin, gmax);
        step(1'b1, bad_stop, bad_stop ? 4 : 3, w);
    endtask

    initial begin
        R = 1'b1;
        @(posedge C);
        #2;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 5, 8'd0);
        step(1'b0, 1'b0, 5, 8'd0);
        chk("reset_po", {24'd0, PO}, 32'h0);

        // First frame after reset, consumer stalled.
        rdy_mode = 1;
        send_frame(8'hA5, 1'b0, 0, 0);
        chk("a5_po", {24'd0, PO}, 32'hA5);

        // Overrun: second word dropped, sticky flag, then cleared.
        send_frame(8'h3C, 1'b0, 0, 0);
        chk("ovr_po",  {24'd0, PO}, 32'hA5);
        chk("ovr_set", {31'd0, OVR}, 32'h1);
        clr_next = 1'b1;
        step(1'b0, 1'b0, 0, 8'd0);
        chk("ovr_clr", {31'd0, OVR}, 32'h0);

        // Handshake on the stop-bit edge swaps in the new word.
        rdy_mode = 3;
        send_frame(8'h0F, 1'b0, 0, 0);
        chk("handoff_po",  {24'd0, PO}, 32'h0F);
        chk("handoff_ovr", {31'd0, OVR}, 32'h0);
        rdy_mode = 2;
        step(1'b0, 1'b0, 0, 8'd0);
        step(1'b0, 1'b0, 0, 8'd0);

        // Bad stop bit.
        rdy_mode = 1;
        send_frame(8'h5A, 1'b1, 0, 0);
        chk("ferr_pulse", {31'd0, FERR}, 32'h1);
        chk("ferr_vld",   {31'd0, VLD},  32'h0);
        chk("ferr_po",    {24'd0, PO},   32'h0F);
        step(1'b0, 1'b0, 0, 8'd0);
        chk("ferr_end",   {31'd0, FERR}, 32'h0);

        // SV gaps between every bit.
        send_frame(8'hC3, 1'b0, 1, 3);
        chk("gap_po", {24'd0, PO}, 32'hC3);

        // Reset mid-frame, then a clean frame.
        step(1'b1, 1'b1, 1, 8'd0);
        repeat (4) step(1'b1, 1'b1, 2, 8'd0);
        step(1'b0, 1'b0, 5, 8'd0);
        chk("abort_po",   {24'd0, PO},   32'h0);
        chk("abort_busy", {31'd0, BUSY}, 32'h0);
        send_frame(8'h81, 1'b0, 0, 0);
        chk("after_abort_po",   {24'd0, PO},   32'h81);
        chk("after_abort_ferr", {31'd0, FERR}, 32'h0);

        // Randomized traffic.
        rdy_mode = 0;
        clr_rate = 12;
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0, 0, 8'd0);
            send_frame(8'($urandom), ($urandom_range(0, 7) == 0), 0, $urandom_range(0, 2));
        end
        clr_rate = 0;
        rdy_mode = 2;
        repeat (4) step(1'b0, 1'b0, 0, 8'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per frame (legal range 2..32).
REQ-002 C  input  1  clock; all state updates on posedge C.
REQ-003 R  input  1  reset, synchronous, active-high.
REQ-004 SI  input  1  serial data bit, sampled only when SV=1.
REQ-005 SV  input  1  serial bit qualifier; SV=0 cycles leave all frame state unchanged.
REQ-006 RDY  input  1  consumer ready; word accepted on a cycle with VLD=1 and RDY=1.
REQ-007 CLR  input  1  clears sticky OVR.
REQ-008 PO  output  WIDTH  parallel word, registered, stable while VLD=1.
REQ-009 VLD  output  1  PO holds an unaccepted word.
REQ-010 BUSY  output  1  frame in progress (state != IDLE).
REQ-011 OVR  output  1  sticky overrun flag.
REQ-012 FERR  output  1  one-cycle framing-error pulse.

Function
REQ-013 Frame format: start bit (1), WIDTH data bits MSB first, stop bit (0); each bit is one SV=1 cycle, arbitrary SV=0 gaps allowed between bits.
REQ-014 FSM states IDLE, DATA, STOP; internal shift register SR[WIDTH-1:0] and bit counter CNT of width ceil(log2(WIDTH+1)).
REQ-015 IDLE: SV=1 and SI=1 -> DATA, CNT<=0; SV=1 and SI=0 ignored (stay IDLE).
REQ-016 DATA: on SV=1, SR<={SR[WIDTH-2:0],SI}, CNT<=CNT+1; when CNT=WIDTH-1 at the shift -> STOP.
REQ-017 STOP: on SV=1 and SI=0 (good frame) -> IDLE, deliver per REQ-018/019.
REQ-018 Delivery: if VLD=0, or VLD=1 and RDY=1 in the same cycle, then PO<=SR and VLD<=1 on that edge.
REQ-019 Overrun: if VLD=1 and RDY=0 at delivery, new word is dropped, PO and VLD unchanged, OVR<=1.
REQ-020 STOP: on SV=1 and SI=1 (bad stop) -> IDLE, FERR=1 for exactly the next cycle, word discarded, PO/VLD/OVR unchanged.
REQ-021 VLD=1 and RDY=1 with no delivery that cycle -> VLD<=0, PO retains value.
REQ-022 Latency: PO/VLD update on the same edge that samples the stop bit; minimum frame is WIDTH+2 SV=1 cycles.
REQ-023 OVR: set per REQ-019, cleared by CLR=1; set and CLR in the same cycle -> OVR=1 (set wins).
REQ-024 Frame reception proceeds independently of VLD/RDY; a new frame may start the cycle after the stop bit.
REQ-025 BUSY=1 in DATA and STOP, combinational from state.
REQ-026 RDY while VLD=0 has no effect; SI while SV=0 is ignored.

Reset
REQ-027 R=1 at posedge C: state<=IDLE, CNT<=0, SR<=0, PO<=0, VLD<=0, OVR<=0, FERR<=0; overrides all other inputs.
REQ-028 R asserted mid-frame aborts the frame with no delivery and no FERR; reception resumes with the next start bit after R deasserts.

Verification
REQ-029 R, then SV=1 continuous, SI=1,1,0,1,0,0,1,0,1,0, RDY=0 -> after 10th edge PO=8'hA5, VLD=1, BUSY=0, OVR=0.
REQ-030 With 8'hA5 pending and RDY=0, send frame 8'h3C -> OVR=1, PO=8'hA5, VLD=1; CLR=1 one cycle -> OVR=0.
REQ-031 Frame 8'h5A with stop bit=1 -> FERR=1 for one cycle, VLD=0, PO unchanged.
REQ-032 Frame 8'hC3 with SV=0 gaps of 1-3 cycles between every bit -> PO=8'hC3, VLD=1; BUSY=1 from start bit edge to stop bit edge.
REQ-033 VLD=1 (8'hA5), RDY=1 on the stop-bit edge of frame 8'h0F -> PO=8'h0F, VLD=1, OVR=0.
REQ-034 R=1 after 4 data bits of frame 8'hFF -> all outputs 0; subsequent frame 8'h81 -> PO=8'h81, VLD=1, FERR=0.
